// File: rtl/latency_mem_responder.sv
// Single-port memory responder with independent read and write channel FSMs
// and fixed, parameterised response latency.
module latency_mem_responder #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1,
    parameter int RD_LAT    = 2,
    parameter int WR_LAT    = 1,
    parameter int MEM_WORDS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 always_success,
    input  logic                 always_error,
    input  logic                 ar_valid,
    output logic                 ar_ready,
    input  logic [ADDR_WDTH-1:0] ar_address,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [DATA_WDTH-1:0] r_data,
    output logic [RESP_WDTH-1:0] r_resp,
    input  logic                 aw_valid,
    output logic                 aw_ready,
    input  logic [ADDR_WDTH-1:0] aw_address,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [DATA_WDTH-1:0] w_data,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [RESP_WDTH-1:0] b_resp,
    output logic [7:0]           rd_count,
    output logic [7:0]           wr_count,
    output logic                 swich_case_default
);

    localparam int DEPTH = 2 ** ADDR_WDTH;
    localparam logic [RESP_WDTH-1:0] RESP_OKAY = '0;
    localparam logic [RESP_WDTH-1:0] RESP_ERR  = RESP_WDTH'(1);
    localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);
    localparam logic [3:0] WR_LAT_C = 4'(WR_LAT);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rd_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wr_state_e;

    // Handshake: a channel transfers on a rising edge where valid && ready are
    // both high; a source holds valid and payload stable until that edge.

    function automatic logic [RESP_WDTH-1:0] resp_for(input logic                 err,
                                                      input logic                 ok,
                                                      input logic [ADDR_WDTH-1:0] addr);
        if (err) return RESP_ERR;
        if (ok) return RESP_OKAY;
        if (32'(addr) >= 32'(MEM_WORDS)) return RESP_ERR;
        return RESP_OKAY;
    endfunction

    logic [DATA_WDTH-1:0] mem_q [DEPTH];

    rd_state_e            rd_state_q, rd_state_d;
    logic [3:0]           rd_cnt_q, rd_cnt_d;
    logic [ADDR_WDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WDTH-1:0] r_data_q;
    logic [RESP_WDTH-1:0] r_resp_q;
    logic                 rd_illegal, rd_enter, ar_fire, r_fire;

    wr_state_e            wr_state_q, wr_state_d;
    logic [3:0]           wr_cnt_q, wr_cnt_d;
    logic [ADDR_WDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WDTH-1:0] wr_data_q, wr_data_d;
    logic                 aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [RESP_WDTH-1:0] b_resp_q, wr_resp;
    logic                 wr_illegal, wr_enter, aw_fire, w_fire, b_fire;

    logic [7:0]           rd_count_q, wr_count_q;
    logic                 swich_q;

    assign ar_fire = ar_valid & ar_ready;
    assign r_fire  = r_valid & r_ready;
    assign aw_fire = aw_valid & aw_ready;
    assign w_fire  = w_valid & w_ready;
    assign b_fire  = b_valid & b_ready;

    // ---------------- read FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
            rd_cnt_q   <= '0;
            rd_addr_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_addr_d  = rd_addr_q;
        rd_illegal = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_fire) begin
                    rd_addr_d  = ar_address;
                    rd_cnt_d   = RD_LAT_C;
                    rd_state_d = (RD_LAT == 0) ? R_RESP : R_WAIT;
                end
            end
            R_WAIT: begin
                rd_cnt_d = rd_cnt_q - 4'd1;
                if (rd_cnt_q <= 4'd1) rd_state_d = R_RESP;
            end
            R_RESP: begin
                if (r_ready) rd_state_d = R_IDLE;
            end
            default: begin
                rd_state_d = R_IDLE;
                rd_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        ar_ready = (rd_state_q == R_IDLE);
        r_valid  = (rd_state_q == R_RESP);
        rd_enter = (rd_state_d == R_RESP) && (rd_state_q != R_RESP);
    end

    // Read data is sampled with the pre-edge RAM contents, so a write
    // committing on the same edge is not visible to this read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_q <= '0;
            r_resp_q <= '0;
        end else if (rd_enter) begin
            r_data_q <= mem_q[rd_addr_d];
            r_resp_q <= resp_for(always_error, always_success, rd_addr_d);
        end
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            wr_cnt_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        wr_illegal = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    wr_addr_d = aw_address;
                    aw_got_d  = 1'b1;
                end
                if (w_fire) begin
                    wr_data_d = w_data;
                    w_got_d   = 1'b1;
                end
                // The later of the two captures starts the latency count.
                if (aw_got_d && w_got_d) begin
                    aw_got_d   = 1'b0;
                    w_got_d    = 1'b0;
                    wr_cnt_d   = WR_LAT_C;
                    wr_state_d = (WR_LAT == 0) ? W_RESP : W_WAIT;
                end
            end
            W_WAIT: begin
                wr_cnt_d = wr_cnt_q - 4'd1;
                if (wr_cnt_q <= 4'd1) wr_state_d = W_RESP;
            end
            W_RESP: begin
                if (b_ready) wr_state_d = W_IDLE;
            end
            default: begin
                wr_state_d = W_IDLE;
                aw_got_d   = 1'b0;
                w_got_d    = 1'b0;
                wr_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        aw_ready = (wr_state_q == W_IDLE) && !aw_got_q;
        w_ready  = (wr_state_q == W_IDLE) && !w_got_q;
        b_valid  = (wr_state_q == W_RESP);
        wr_enter = (wr_state_d == W_RESP) && (wr_state_q != W_RESP);
        wr_resp  = resp_for(always_error, always_success, wr_addr_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_resp_q <= '0;
        end else if (wr_enter) begin
            b_resp_q <= wr_resp;
        end
    end

    // RAM has no reset; a commit needs reset released and an OKAY response.
    always_ff @(posedge clk) begin
        if (rst_n && wr_enter && (wr_resp == RESP_OKAY)) begin
            mem_q[wr_addr_d] <= wr_data_d;
        end
    end

    // ---------------- counters and sticky flag ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
            swich_q    <= 1'b0;
        end else begin
            if (r_fire) rd_count_q <= rd_count_q + 8'd1;
            if (b_fire) wr_count_q <= wr_count_q + 8'd1;
            swich_q <= swich_q | rd_illegal | wr_illegal;
        end
    end

    assign r_data             = r_data_q;
    assign r_resp             = r_resp_q;
    assign b_resp             = b_resp_q;
    assign rd_count           = rd_count_q;
    assign wr_count           = wr_count_q;
    assign swich_case_default = swich_q;

endmodule

// File: tb/tb_latency_mem_responder.sv
// Directed plus randomized bench for latency_mem_responder; a word-array
// memory model and fixed latency figures provide every expected value.
module tb_latency_mem_responder;

    localparam int RD_LAT    = 2;
    localparam int WR_LAT    = 1;
    localparam int MEM_WORDS = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        always_success, always_error;
    logic        ar_valid, ar_ready;
    logic [3:0]  ar_address;
    logic        r_valid, r_ready;
    logic [31:0] r_data;
    logic [0:0]  r_resp;
    logic        aw_valid, aw_ready;
    logic [3:0]  aw_address;
    logic        w_valid, w_ready;
    logic [31:0] w_data;
    logic        b_valid, b_ready;
    logic [0:0]  b_resp;
    logic [7:0]  rd_count, wr_count;
    logic        swich_case_default;

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents and completed-transaction counts.
    logic [31:0] mem_m [MEM_WORDS];
    bit          known_m [MEM_WORDS];
    int          rd_cnt_m = 0;
    int          wr_cnt_m = 0;

    latency_mem_responder dut (
        .clk(clk), .rst_n(rst_n),
        .always_success(always_success), .always_error(always_error),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_address(ar_address),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_address(aw_address),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .rd_count(rd_count), .wr_count(wr_count),
        .swich_case_default(swich_case_default)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic resp_m(input logic [3:0] a);
        if (always_error) return 1'b1;
        if (always_success) return 1'b0;
        return (int'(a) >= MEM_WORDS) ? 1'b1 : 1'b0;
    endfunction

    // w_lead > 0: w is presented w_lead cycles before aw; < 0: aw leads; 0: same edge.
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input int w_lead);
        int   cyc;
        logic exp_resp;
        @(negedge clk);
        if (w_lead > 0) begin
            w_valid = 1'b1; w_data = data;
            @(negedge clk);
            w_valid = 1'b0;
            check("w_ready_low_after_w", 64'(w_ready), 64'd0);
            check("aw_ready_while_waiting", 64'(aw_ready), 64'd1);
            repeat (w_lead - 1) @(negedge clk);
            aw_valid = 1'b1; aw_address = addr;
            @(negedge clk);
            aw_valid = 1'b0;
        end else if (w_lead < 0) begin
            aw_valid = 1'b1; aw_address = addr;
            @(negedge clk);
            aw_valid = 1'b0;
            check("aw_ready_low_after_aw", 64'(aw_ready), 64'd0);
            repeat (-w_lead - 1) @(negedge clk);
            w_valid = 1'b1; w_data = data;
            @(negedge clk);
            w_valid = 1'b0;
        end else begin
            aw_valid = 1'b1; aw_address = addr;
            w_valid = 1'b1; w_data = data;
            @(negedge clk);
            aw_valid = 1'b0; w_valid = 1'b0;
        end
        exp_resp = resp_m(addr);
        // The capture cycle is cycle 0; we now sit in cycle 1.
        cyc = 1;
        while (!b_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("b_latency", 64'(cyc), 64'(WR_LAT + 1));
        check("b_resp", 64'(b_resp), 64'(exp_resp));
        if (!exp_resp) begin
            mem_m[addr] = data;
            known_m[addr] = 1'b1;
        end
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        wr_cnt_m = (wr_cnt_m + 1) % 256;
        check("b_valid_after_b", 64'(b_valid), 64'd0);
        check("aw_ready_after_b", 64'(aw_ready), 64'd1);
        check("w_ready_after_b", 64'(w_ready), 64'd1);
        check("wr_count", 64'(wr_count), 64'(wr_cnt_m));
    endtask

    task automatic do_read(input logic [3:0] addr, input int hold);
        int cyc;
        @(negedge clk);
        ar_valid = 1'b1; ar_address = addr;
        @(negedge clk);
        ar_valid = 1'b0;
        check("ar_ready_low_after_ar", 64'(ar_ready), 64'd0);
        cyc = 1;
        while (!r_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("r_latency", 64'(cyc), 64'(RD_LAT + 1));
        check("r_data", 64'(r_data), 64'(mem_m[addr]));
        check("r_resp", 64'(r_resp), 64'(resp_m(addr)));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("r_valid_held", 64'(r_valid), 64'd1);
            check("r_data_held", 64'(r_data), 64'(mem_m[addr]));
            check("ar_ready_held_low", 64'(ar_ready), 64'd0);
        end
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        rd_cnt_m = (rd_cnt_m + 1) % 256;
        check("r_valid_after_r", 64'(r_valid), 64'd0);
        check("ar_ready_after_r", 64'(ar_ready), 64'd1);
        check("rd_count", 64'(rd_count), 64'(rd_cnt_m));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ar_ready"}, 64'(ar_ready), 64'd1);
        check({tag, "_aw_ready"}, 64'(aw_ready), 64'd1);
        check({tag, "_w_ready"}, 64'(w_ready), 64'd1);
        check({tag, "_r_valid"}, 64'(r_valid), 64'd0);
        check({tag, "_b_valid"}, 64'(b_valid), 64'd0);
        check({tag, "_r_data"}, 64'(r_data), 64'd0);
        check({tag, "_r_resp"}, 64'(r_resp), 64'd0);
        check({tag, "_b_resp"}, 64'(b_resp), 64'd0);
        check({tag, "_rd_count"}, 64'(rd_count), 64'd0);
        check({tag, "_wr_count"}, 64'(wr_count), 64'd0);
        check({tag, "_swich"}, 64'(swich_case_default), 64'd0);
    endtask

    logic [3:0]  tgt;
    logic [31:0] old_v, new_v;

    initial begin
        rst_n = 1'b0;
        always_success = 1'b0; always_error = 1'b0;
        ar_valid = 1'b0; ar_address = '0; r_ready = 1'b0;
        aw_valid = 1'b0; aw_address = '0; w_valid = 1'b0; w_data = '0; b_ready = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) known_m[i] = 1'b0;

        // Clock / reset
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Basic write then read with forced OKAY.
        always_success = 1'b1;
        do_write(4'd3, 32'hDEAD_BEEF, 0);
        do_read(4'd3, 0);
        check("s1_rd_count", 64'(rd_count), 64'd1);
        check("s1_wr_count", 64'(wr_count), 64'd1);

        // w leads aw by four cycles.
        do_write(4'd7, $urandom, 4);
        do_read(4'd7, 0);

        // Fill the whole memory with random data and random channel ordering.
        always_success = 1'b0;
        for (int a = 0; a < MEM_WORDS; a++) begin
            do_write(4'(a), $urandom, int'($urandom_range(6, 0)) - 3);
        end

        // Forced ERROR beats forced OKAY; memory must be untouched.
        always_error = 1'b1; always_success = 1'b1;
        old_v = mem_m[5];
        do_write(4'd5, 32'h1234_5678, 0);
        do_read(4'd5, 0);
        always_error = 1'b0;
        do_read(4'd5, 0);
        check("err_ram5_unchanged", 64'(mem_m[5]), 64'(old_v));

        // Read response backpressured for six cycles.
        do_read(4'($urandom_range(15, 0)), 6);

        // Random mixed traffic under random response forcing.
        for (int n = 0; n < 24; n++) begin
            always_error = 1'($urandom_range(3, 0) == 0);
            always_success = 1'($urandom_range(1, 0));
            if ($urandom_range(1, 0) == 1)
                do_write(4'($urandom_range(15, 0)), $urandom, int'($urandom_range(6, 0)) - 3);
            else
                do_read(4'($urandom_range(15, 0)), int'($urandom_range(3, 0)));
        end
        always_error = 1'b0; always_success = 1'b0;

        // Reset pulsed while both FSMs are waiting.
        tgt = 4'd9;
        old_v = mem_m[tgt];
        @(negedge clk);
        ar_valid = 1'b1; ar_address = tgt;
        aw_valid = 1'b1; aw_address = tgt; w_valid = 1'b1; w_data = ~old_v;
        @(negedge clk);
        ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
        check("pre_rst_r_wait", 64'(r_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rd_cnt_m = 0; wr_cnt_m = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_no_r_valid", 64'(r_valid), 64'd0);
            check("post_rst_no_b_valid", 64'(b_valid), 64'd0);
        end
        do_read(tgt, 0);

        // 256 writes wrap the write counter back to its starting value.
        for (int n = 0; n < 256; n++) begin
            do_write(4'($urandom_range(15, 0)), $urandom, int'($urandom_range(4, 0)) - 2);
        end
        check("wr_count_wrap", 64'(wr_count), 64'd0);

        // Write commits on the very edge the read samples: read sees old data.
        tgt = 4'($urandom_range(15, 0));
        old_v = mem_m[tgt];
        new_v = ~old_v;
        @(negedge clk);
        ar_valid = 1'b1; ar_address = tgt;
        @(negedge clk);
        ar_valid = 1'b0;
        aw_valid = 1'b1; aw_address = tgt; w_valid = 1'b1; w_data = new_v;
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0;
        check("conc_r_not_yet", 64'(r_valid), 64'd0);
        check("conc_b_not_yet", 64'(b_valid), 64'd0);
        @(negedge clk);
        check("conc_r_valid", 64'(r_valid), 64'd1);
        check("conc_b_valid", 64'(b_valid), 64'd1);
        check("conc_r_data_old", 64'(r_data), 64'(old_v));
        check("conc_b_resp", 64'(b_resp), 64'd0);
        r_ready = 1'b1; b_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0; b_ready = 1'b0;
        mem_m[tgt] = new_v;
        rd_cnt_m = (rd_cnt_m + 1) % 256;
        wr_cnt_m = (wr_cnt_m + 1) % 256;
        check("conc_rd_count", 64'(rd_count), 64'(rd_cnt_m));
        check("conc_wr_count", 64'(wr_count), 64'(wr_cnt_m));
        do_read(tgt, 0);
        check("final_swich", 64'(swich_case_default), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
